// File: rtl/simd_operand_sequencer.sv
// simd_operand_sequencer: operand-pair buffer plus command sequencer that
// presents one instruction and then streams a burst of operand pairs to the
// SIMD core under valid/ready backpressure.
// Optional feature macro: SIMD_SEQ_LOOP_EN (cmd_loop / loop_stop ports,
// repeating bursts until stopped).
module simd_operand_sequencer #(
   parameter  int LANES   = 4,
   parameter  int LANE_W  = 32,
   parameter  int DEPTH   = 64,
   parameter  int INSTR_W = 3,
   localparam int OPW     = LANES * LANE_W,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_en,
   input  logic [AW-1:0]      wr_addr,
   input  logic [OPW-1:0]     wr_opa,
   input  logic [OPW-1:0]     wr_opb,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [INSTR_W-1:0] cmd_instr,
   input  logic [AW-1:0]      cmd_base,
   input  logic [AW:0]        cmd_count,
`ifdef SIMD_SEQ_LOOP_EN
   input  logic               cmd_loop,
   input  logic               loop_stop,
`endif
   input  logic               core_ready,
   output logic               valid_instruction,
   output logic [INSTR_W-1:0] instruction,
   output logic               valid_data,
   output logic [AW:0]        data_size,
   output logic [OPW-1:0]     mc_data_in_opa,
   output logic [OPW-1:0]     mc_data_in_opb,
   output logic               busy,
   output logic               done,
   output logic               cmd_err
);

   typedef enum logic [1:0] {IDLE, ISSUE, STREAM, FIN} state_t;

   state_t state, state_nx;

   logic [OPW-1:0] mem_a [DEPTH];
   logic [OPW-1:0] mem_b [DEPTH];

   logic [AW-1:0] base_q;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   remaining;   // beats left, including the one on the outputs

   logic bad_count;
   logic cmd_fire;
   logic accept_cmd;
   logic beat_take;
   logic last_beat;
   logic finish;
   logic loop_back;

   assign bad_count  = (cmd_count == '0) || (cmd_count > (AW+1)'(DEPTH));
   assign cmd_fire   = cmd_valid & cmd_ready;
   assign accept_cmd = cmd_fire & ~bad_count;
   assign beat_take  = (state == STREAM) & core_ready;
   assign last_beat  = (remaining == (AW+1)'(1));

`ifdef SIMD_SEQ_LOOP_EN
   logic loop_q;
   logic stop_q;   // stop requested while the current beat was still stalled

   // A looping burst ends on the first accepted beat at or after loop_stop.
   assign finish    = beat_take & (loop_q ? (stop_q | loop_stop) : last_beat);
   assign loop_back = beat_take & loop_q & ~(stop_q | loop_stop) & last_beat;

   // Loop mode and pending-stop flags, captured per command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         loop_q <= 1'b0;
         stop_q <= 1'b0;
      end else if (accept_cmd) begin
         loop_q <= cmd_loop;
         stop_q <= 1'b0;
      end else if ((state == STREAM) && loop_q && loop_stop && !core_ready) begin
         stop_q <= 1'b1;
      end
   end
`else
   assign finish    = beat_take & last_beat;
   assign loop_back = 1'b0;
`endif

   // Operand buffer: plain RAM, never reset; reads below see pre-write data.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_a[wr_addr] <= wr_opa;
         mem_b[wr_addr] <= wr_opb;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept_cmd) state_nx = ISSUE;
         ISSUE:   state_nx = STREAM;
         STREAM:  if (finish) state_nx = FIN;
         FIN:     state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // FSM output decode.
   always_comb begin
      valid_instruction = (state == ISSUE);
      valid_data        = (state == STREAM);
      busy              = (state != IDLE);
      done              = (state == FIN);
   end

   // Handshake flags: cmd_ready is low through reset and high only in IDLE;
   // cmd_err pulses the cycle after a rejected command.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cmd_ready <= 1'b0;
         cmd_err   <= 1'b0;
      end else begin
         cmd_ready <= (state_nx == IDLE);
         cmd_err   <= cmd_fire & bad_count;
      end
   end

   // Command latch, read pointer and output beat registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instruction    <= '0;
         data_size      <= '0;
         base_q         <= '0;
         rd_ptr         <= '0;
         remaining      <= '0;
         mc_data_in_opa <= '0;
         mc_data_in_opb <= '0;
      end else if (accept_cmd) begin
         instruction <= cmd_instr;
         data_size   <= cmd_count;
         base_q      <= cmd_base;
         rd_ptr      <= cmd_base;
         remaining   <= cmd_count;
      end else if (state == ISSUE) begin
         // First beat is staged while the instruction is presented.
         mc_data_in_opa <= mem_a[rd_ptr];
         mc_data_in_opb <= mem_b[rd_ptr];
         rd_ptr         <= rd_ptr + 1'b1;
      end else if (beat_take && !finish) begin
         if (loop_back) begin
            mc_data_in_opa <= mem_a[base_q];
            mc_data_in_opb <= mem_b[base_q];
            rd_ptr         <= base_q + 1'b1;
            remaining      <= data_size;
         end else begin
            mc_data_in_opa <= mem_a[rd_ptr];
            mc_data_in_opb <= mem_b[rd_ptr];
            rd_ptr         <= rd_ptr + 1'b1;   // wraps mod DEPTH
            remaining      <= remaining - 1'b1;
         end
      end
   end

endmodule
